// File: rtl/reg_file_wordline_array.sv
// 16 x DATA_W register file driven by one-hot read/write wordlines; R0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_wordline_array #(
    parameter int DATA_W  = 16,
    parameter int NUM_REG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        SrcReg1,
    input  logic [3:0]        SrcReg2,
    input  logic [3:0]        DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    localparam int ID_W = 4;

    logic [NUM_REG-1:0] rd_wl1;
    logic [NUM_REG-1:0] rd_wl2;
    // Write wordline has no bit for R0: writes there have nowhere to land.
    logic [NUM_REG-1:1] wr_wl;
    logic [DATA_W-1:0]  reg_val [NUM_REG];
    logic [DATA_W-1:0]  rd_data1;
    logic [DATA_W-1:0]  rd_data2;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_rd_wl
            assign rd_wl1[gi] = (SrcReg1 == ID_W'(gi));
            assign rd_wl2[gi] = (SrcReg2 == ID_W'(gi));
        end

        for (gi = 1; gi < NUM_REG; gi++) begin : g_wr_wl
            assign wr_wl[gi] = WriteReg && (DstReg == ID_W'(gi));
        end

        for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_val[gi] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] data_q;
                logic [DATA_W-1:0] data_d;

                always_comb begin
                    data_d = data_q;
                    if (wr_wl[gi]) begin
                        data_d = DstData;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_q <= '0;
                    end else begin
                        data_q <= data_d;
                    end
                end

                assign reg_val[gi] = data_q;
            end
        end
    endgenerate

    // AND-OR readout: each wordline gates exactly one register onto the port.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            rd_data1 = rd_data1 | (reg_val[i] & {DATA_W{rd_wl1[i]}});
            rd_data2 = rd_data2 | (reg_val[i] & {DATA_W{rd_wl2[i]}});
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    // Match on wordlines above R0 only, so R0 reads are never forwarded.
    always_comb begin
        byp1 = !rst && (|(wr_wl & rd_wl1[NUM_REG-1:1]));
        byp2 = !rst && (|(wr_wl & rd_wl2[NUM_REG-1:1]));
    end

    assign SrcData1 = byp1 ? DstData : rd_data1;
    assign SrcData2 = byp2 ? DstData : rd_data2;
`else
    assign SrcData1 = rd_data1;
    assign SrcData2 = rd_data2;
`endif

endmodule

// File: doc/reg_file_wordline_array.md
Name: reg_file_wordline_array

Overview:
- 16-entry x 16-bit general-purpose register file for the single-cycle/pipelined WISC datapath.
- Sits directly downstream of the 4-to-16 read/write decoders and consumes their one-hot wordlines.
- Two combinational read ports and one clocked write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 16, width of each register and of every data port.
- NUM_REG, 16, number of registers; must equal 2^4 (the register IDs are 4 bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- SrcReg1  input  4  register ID for read port 1.
- SrcReg2  input  4  register ID for read port 2.
- DstReg  input  4  register ID for the write port.
- WriteReg  input  1  write enable for the write port.
- DstData  input  DATA_W  write data.
- SrcData1  output  DATA_W  read data, port 1.
- SrcData2  output  DATA_W  read data, port 2.

Behaviour:
- Storage: NUM_REG registers, each DATA_W flops. Each register is selected by one bit of a one-hot 16-bit wordline.
- Wordline generation:
  - Read wordlines = 16'h0001 << SrcRegN.
  - Write wordline = (16'h0001 << DstReg) when WriteReg=1; 16'h0000 otherwise.
  - Each wordline has exactly one bit set, or none for the write port when WriteReg=0.
- Reset:
  - rst=1 at a rising edge clears all 16 registers to 0, and rst takes priority over any write that cycle.
  - After reset, SrcData1 and SrcData2 read 0 for every ID.
  - Reset mid-operation discards any write presented in that cycle.
- Write:
  - At the rising edge, when rst=0, WriteReg=1 and DstReg!=0, register[DstReg] <= DstData.
  - All other registers hold their value.
  - A write to DstReg=0 is silently dropped; register 0 stays 0 permanently.
- Read:
  - Purely combinational from the current register contents, zero-cycle latency.
  - SrcData1 = register[SrcReg1]; SrcData2 = register[SrcReg2].
  - SrcRegN=0 always returns 0.
- Both read ports may address the same register, and both return the same value.
- Read and write to the same register in the same cycle (no bypass build): the read returns the old value, and the new value is visible after the rising edge.
- No X propagation: every register has a defined value from the first reset onward.
- Write ID out of range cannot occur, since 4 bits address exactly 16 entries.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-before-read bypass):
  - If WriteReg=1, DstReg!=0 and SrcRegN==DstReg, then SrcDataN = DstData in the same cycle.
  - The bypass applies to each port independently.
  - A write to register 0 is never bypassed, so reads of register 0 still return 0.
  - During rst=1 the bypass is suppressed and reads return the register contents.
- Undefined: no bypass; reads always return the stored register value, as described under Behaviour.

Test Plan:
- Reset clears all registers: assert rst 1 cycle after writing 16'hBEEF to R5 -> SrcReg1=5 reads 16'h0000.
- Write then read: write 16'h1234 to R3, next cycle SrcReg1=3 and SrcReg2=3 -> both outputs read 16'h1234.
- Zero register: WriteReg=1, DstReg=0, DstData=16'hFFFF, then SrcReg1=0 -> reads 16'h0000 (also 0 same-cycle with REGFILE_BYPASS_EN).
- Write disabled: R7=16'h00AA, then WriteReg=0, DstReg=7, DstData=16'h5555 -> R7 still 16'h00AA.
- Same-cycle read/write of R9 (old value 16'h0001, new value 16'h8000):
  - Without the macro, the read returns 16'h0001 that cycle and 16'h8000 the next.
  - With REGFILE_BYPASS_EN, the read returns 16'h8000 immediately.
- Sweep and reset priority:
  - Write R1..R15 with value 16'h1000+i, then read all pairs -> each port returns the matching value.
  - Assert rst together with a write to R4 -> R4 reads 16'h0000 afterward.
